// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW memory-port arbiter: FSM encoding,
// default fetch bundle size and the encoding of the round-robin priority bit.
package vliw_pkg;

  localparam int IF_BEATS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    LSU_ACC,
    IF_BURST,
    IF_DRAIN
  } arb_state_t;

  localparam logic PRIO_LSU = 1'b0;
  localparam logic PRIO_IF  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (multi-beat
// bundle bursts) and the LSU (single-word accesses), alternating on contention.
module mem_port_arbiter
  import vliw_pkg::*;
#(
  parameter int IF_BEATS = IF_BEATS_DEFAULT,
  parameter int ADDR_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [ADDR_W-1:0]      if_addr,
  output logic                   if_valid,
  output logic [32*IF_BEATS-1:0] if_bundle,
  input  logic                   branch_squash,
  input  logic                   lsu_req,
  input  logic                   lsu_we,
  input  logic [ADDR_W-1:0]      lsu_addr,
  input  logic [31:0]            lsu_wdata,
  output logic                   lsu_valid,
  output logic [31:0]            lsu_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  output logic                   stall_out
);

  localparam int BEAT_W = 2;

  arb_state_t            state_q;
  logic [BEAT_W-1:0]     beat_q;
  logic                  prio_q;
  logic                  if_valid_q;
  logic                  lsu_valid_q;
  logic [32*IF_BEATS-1:0] if_bundle_q;
  logic [31:0]           lsu_rdata_q;

  logic ifAct;
  logic lsuAct;
  logic grantLsu;
  logic grantIf;
  logic serveLsu;
  logic serveIf;
  logic lastBeat;
  logic unusedAddrBits;

  // A requester whose completion pulse is showing this cycle is not re-granted,
  // so a request still held during its own valid cycle cannot restart.
  always_comb begin
    ifAct    = if_req & ~if_valid_q & ~branch_squash;
    lsuAct   = lsu_req & ~lsu_valid_q;
    grantLsu = 1'b0;
    grantIf  = 1'b0;
    if (state_q == IDLE && !rst) begin
      grantLsu = lsuAct & (~ifAct | (prio_q == PRIO_LSU));
      grantIf  = ifAct & ~grantLsu;
    end
    serveLsu = grantLsu | (state_q == LSU_ACC);
    serveIf  = grantIf | (state_q == IF_BURST) | (state_q == IF_DRAIN);
    lastBeat = (beat_q == BEAT_W'(IF_BEATS - 1));

    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (serveLsu) begin
      mem_req   = 1'b1;
      mem_we    = lsu_we;
      mem_addr  = lsu_addr;
      mem_wdata = lsu_wdata;
    end else if (serveIf) begin
      mem_req  = 1'b1;
      mem_addr = {if_addr[ADDR_W-1:4], beat_q, 2'b00};
    end
  end

  assign unusedAddrBits = ^if_addr[3:0];

  // The grant cycle in IDLE is already the first memory cycle, so an ack
  // there completes a beat exactly as it would in LSU_ACC/IF_BURST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      prio_q      <= PRIO_LSU;
      if_valid_q  <= 1'b0;
      lsu_valid_q <= 1'b0;
      if_bundle_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      if_valid_q  <= 1'b0;
      lsu_valid_q <= 1'b0;
      if (serveLsu) begin
        if (mem_ack) begin
          lsu_rdata_q <= mem_rdata;
          lsu_valid_q <= 1'b1;
          prio_q      <= PRIO_IF;
          state_q     <= IDLE;
        end else begin
          state_q <= LSU_ACC;
        end
      end else if (serveIf) begin
        if (mem_ack) begin
          if (state_q != IF_DRAIN && !branch_squash) begin
            if_bundle_q[32*int'(beat_q) +: 32] <= mem_rdata;
          end
          if (lastBeat || branch_squash || state_q == IF_DRAIN) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            prio_q     <= PRIO_LSU;
            if_valid_q <= lastBeat & ~branch_squash & (state_q != IF_DRAIN);
          end else begin
            beat_q  <= beat_q + 2'd1;
            state_q <= IF_BURST;
          end
        end else begin
          state_q <= (branch_squash || state_q == IF_DRAIN) ? IF_DRAIN : IF_BURST;
        end
      end
    end
  end

  assign if_valid  = if_valid_q;
  assign lsu_valid = lsu_valid_q;
  assign if_bundle = if_bundle_q;
  assign lsu_rdata = lsu_rdata_q;
  assign stall_out = (if_req & ~if_valid_q) | (lsu_req & ~lsu_valid_q);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter IF_BEATS, default 4: number of 32-bit beats per instruction bundle.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port if_req  input  1  fetch requests a bundle; held until if_valid or squash.
REQ-006 SHALL have port if_addr  input  ADDR_W  bundle address; stable while if_req is high; low 4 bits ignored.
REQ-007 SHALL have port if_valid  output  1  one-cycle pulse: if_bundle is complete.
REQ-008 SHALL have port if_bundle  output  32*IF_BEATS  assembled bundle; beat i in bits [32i+31:32i].
REQ-009 SHALL have port branch_squash  input  1  kills the in-flight or pending fetch.
REQ-010 SHALL have port lsu_req  input  1  LSU access request; held until lsu_valid.
REQ-011 SHALL have port lsu_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port lsu_addr  input  ADDR_W  word address.
REQ-013 SHALL have port lsu_wdata  input  32  store data.
REQ-014 SHALL have port lsu_valid  output  1  one-cycle pulse: access done; lsu_rdata is valid for loads.
REQ-015 SHALL have port lsu_rdata  output  32  load data.
REQ-016 SHALL have ports mem_req / mem_we / mem_addr / mem_wdata  output  1/1/ADDR_W/32  single-port memory request.
REQ-017 SHALL have ports mem_ack / mem_rdata  input  1/32  beat completion and read data, both valid in the same cycle.
REQ-018 SHALL have port stall_out  output  1  high while any requester is waiting for service or completion.

Function
REQ-019 SHALL implement FSM states IDLE, LSU_ACC, IF_BURST and IF_DRAIN.
REQ-020 IDLE SHALL select the grant on the same cycle and drive mem_req combinationally from the selected requester.
REQ-021 When only one requester is active, that requester SHALL win.
REQ-022 When both are active, the winner SHALL be the one indicated by the prio bit; after each completed grant, prio SHALL point to the other requester.
REQ-023 In LSU_ACC, the arbiter SHALL hold mem_req=1, mem_we=lsu_we, mem_addr=lsu_addr and mem_wdata=lsu_wdata until mem_ack.
REQ-024 On ack in LSU_ACC, the arbiter SHALL register mem_rdata into lsu_rdata, pulse lsu_valid in the next cycle, and return to IDLE.
REQ-025 In IF_BURST, the arbiter SHALL drive mem_we=0 and mem_addr={if_addr[ADDR_W-1:4], beat, 2'b00}; the 2-bit beat counter SHALL start at 0 and increment on each ack.
REQ-026 mem_req SHALL stay high across beats; the new address SHALL appear the cycle after the ack.
REQ-027 Each acked beat SHALL be written into its if_bundle slot.
REQ-028 On the ack of beat IF_BEATS-1, the arbiter SHALL pulse if_valid next cycle and return to IDLE.
REQ-029 Minimum latency: LSU access with ack in the first cycle completes with lsu_valid 1 cycle later; a 4-beat burst with immediate acks completes with if_valid 4 cycles after grant.
REQ-030 branch_squash in IDLE SHALL block fetch selection that cycle.
REQ-031 branch_squash in IF_BURST without a same-cycle ack SHALL move the FSM to IF_DRAIN; in IF_DRAIN the arbiter SHALL keep the current beat's request until ack, then go to IDLE with no if_valid.
REQ-032 branch_squash coinciding with the final ack SHALL suppress if_valid.
REQ-033 A squashed fetch SHALL still count as a completed grant for prio.
REQ-034 LSU requests SHALL never be preempted mid-access; fetch bursts SHALL never be interleaved with LSU beats.
REQ-035 mem_req SHALL be 0 in IDLE when no request is selected; memory outputs SHALL be 0 when mem_req=0.
REQ-036 stall_out SHALL equal (if_req & ~if_valid) | (lsu_req & ~lsu_valid).
REQ-037 if_bundle and lsu_rdata SHALL hold their last value between completions.

Reset
REQ-038 rst SHALL asynchronously force: state=IDLE, beat=0, prio=LSU, if_valid=0, lsu_valid=0, if_bundle=0, lsu_rdata=0.
REQ-039 rst asserted mid-burst SHALL abandon the burst; after release, no pulse SHALL be emitted for the abandoned request.
REQ-040 The first cycle after reset release SHALL arbitrate normally.

Structure
REQ-041 Shared package vliw_pkg SHALL hold the arb_state_t enum and the IF_BEATS default constant.
REQ-042 The design SHALL be a single module with no sub-modules; the beat counter and prio flop SHALL be inline.

Verification
REQ-043 Fetch only: if_addr=0x0000_0104, acks every cycle -> mem_addr 0x100, 0x104, 0x108, 0x10C; if_valid 4 cycles after grant; bundle beats in order.
REQ-044 Simultaneous requests after reset: LSU load 0x200 first (rdata 0xDEADBEEF, lsu_valid pulse), then the fetch burst; with both requests held, grants SHALL alternate.
REQ-045 Store with mem_ack delayed 3 cycles: mem_we=1, address and data stable for 4 cycles; lsu_valid 1 cycle after ack; stall_out high throughout.
REQ-046 Squash after the beat-1 ack while beat 2 is pending with no ack -> IF_DRAIN; beat 2 completes; no if_valid; the next grant goes to a pending LSU request.
REQ-047 rst pulse during beat 2 -> all outputs 0 immediately; no if_valid or lsu_valid afterward until a new request.
